median5_stream_sched: RTL and testbench

//  Streaming median-of-5 filter controller. Keeps a 5-sample sliding window and

---
 rtl/median5_stream_sched_pkg.sv | 26 ++
 rtl/median5_stream_sched_if.sv | 29 ++
 rtl/median5_stream_sched_cmp_swap.sv | 23 ++
 rtl/median5_stream_sched.sv | 140 ++++++++++++++
 tb/tb_median5_stream_sched.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/median5_stream_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | median5_pkg                                                          |
// | Shared constants, state encoding and sort schedule for median5.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package median5_pkg;

    localparam int WIN   = 5;
    localparam int MID   = 2;
    localparam int NSTEP = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        SORT   = 2'd2,
        OUT    = 2'd3
    } state_e;

    // Odd-even transposition: five phases serialised into single compare-exchanges
    localparam logic [2:0] PAIR_LO [NSTEP] = '{
        3'd0, 3'd2, 3'd1, 3'd3, 3'd0, 3'd2, 3'd1, 3'd3, 3'd0, 3'd2
    };

endpackage
`default_nettype wire

// File: rtl/median5_stream_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | median5_stream_sched_if                                              |
// | Input/output valid-ready streams plus flush and busy for median5.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface median5_stream_sched_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/median5_stream_sched_cmp_swap.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | median5_cmp_swap                                                     |
// | Combinational unsigned compare-exchange: lo=min, hi=max.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module median5_cmp_swap #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             swapped
);
    // Strict compare so equal values are never exchanged
    always_comb begin
        swapped = (a > b);
        lo      = swapped ? b : a;
        hi      = swapped ? a : b;
    end
endmodule
`default_nettype wire

// File: rtl/median5_stream_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | median5_stream_sched                                                 |
// | Streaming median-of-5 with one shared compare-exchange unit.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module median5_stream_sched
    import median5_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    median5_stream_sched_if.slave  bus
);

    state_e           state_q,     state_d;
    logic [2:0]       cnt_q,       cnt_d;
    logic [3:0]       step_q,      step_d;
    logic [WIDTH-1:0] win_q [WIN];
    logic [WIDTH-1:0] win_d [WIN];
    logic [WIDTH-1:0] srt_q [WIN];
    logic [WIDTH-1:0] srt_d [WIN];
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;

    logic [2:0]       pair_k;
    logic [WIDTH-1:0] cmp_a, cmp_b, cmp_lo, cmp_hi;
    logic             cmp_swapped;

    assign pair_k = PAIR_LO[step_q];
    assign cmp_a  = srt_q[pair_k];
    assign cmp_b  = srt_q[pair_k + 3'd1];

    median5_cmp_swap #(.WIDTH(WIDTH)) u_cmp_swap (
        .a       (cmp_a),
        .b       (cmp_b),
        .lo      (cmp_lo),
        .hi      (cmp_hi),
        .swapped (cmp_swapped)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            step_q      <= 4'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < WIN; i++) begin
                win_q[i] <= '0;
                srt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            win_q       <= win_d;
            srt_q       <= srt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        step_d      = step_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        win_d       = win_q;
        srt_d       = srt_q;

        if (bus.flush) begin
            cnt_d       = 3'd0;
            step_d      = 4'd0;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = ACCEPT;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_d = 1'b1;
                    state_d    = ACCEPT;
                end
                ACCEPT: begin
                    if (bus.in_valid && in_ready_q) begin
                        win_d[0] = bus.in_data;
                        for (int i = 1; i < WIN; i++) begin
                            win_d[i] = win_q[i-1];
                        end
                        // Window already holds four or more: this sample completes it
                        if (cnt_q >= 3'(WIN - 1)) begin
                            cnt_d      = 3'(WIN);
                            srt_d      = win_d;
                            step_d     = 4'd0;
                            in_ready_d = 1'b0;
                            state_d    = SORT;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                SORT: begin
                    if (cmp_swapped) begin
                        srt_d[pair_k]        = cmp_lo;
                        srt_d[pair_k + 3'd1] = cmp_hi;
                    end
                    // Final step's exchange is forwarded straight into out_data
                    if (step_q == 4'(NSTEP - 1)) begin
                        out_data_d  = srt_d[MID];
                        out_valid_d = 1'b1;
                        state_d     = OUT;
                    end else begin
                        step_d = step_q + 4'd1;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_d = 1'b0;
                        in_ready_d  = 1'b1;
                        state_d     = ACCEPT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = (state_q == SORT) || (state_q == OUT);

endmodule
`default_nettype wire

// File: tb/tb_median5_stream_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_median5_stream_sched                                              |
// | Self-checking bench: directed tables, corner sequences, random+model.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_median5_stream_sched;

    localparam int WIDTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    median5_stream_sched_if #(.WIDTH(WIDTH)) bus ();

    median5_stream_sched #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] s [5];
        int         med;
        int         stall;
    } vec_t;

    vec_t tbl [6];

    // Reference: window is the last five accepted samples, median by rank count
    logic [7:0] mwin [$];

    function automatic void model_flush();
        mwin.delete();
    endfunction

    function automatic bit model_push(input logic [7:0] d);
        mwin.push_front(d);
        if (mwin.size() > 5) void'(mwin.pop_back());
        return (mwin.size() == 5);
    endfunction

    function automatic int model_median();
        for (int i = 0; i < mwin.size(); i++) begin
            int lt = 0;
            int le = 0;
            for (int j = 0; j < mwin.size(); j++) begin
                if (mwin[j] <  mwin[i]) lt++;
                if (mwin[j] <= mwin[i]) le++;
            end
            if (lt <= 2 && le >= 3) return int'(mwin[i]);
        end
        return -1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input string name);
        int w = 0;
        while (bus.in_ready !== 1'b1 && w < 40) begin
            tick();
            w++;
        end
        if (bus.in_ready !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s in_ready timeout: got %0d, expected 1", name, bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_out(input int exp, input int stall, input string name);
        int lat = 0;
        int bad = 0;
        while (bus.out_valid !== 1'b1 && lat < 14) begin
            tick();
            lat++;
        end
        check({name, " latency"}, lat, 10);
        check({name, " median"}, int'(bus.out_data), exp);
        if (stall > 0) begin
            bus.out_ready = 1'b0;
            for (int c = 0; c < stall; c++) begin
                tick();
                if (bus.out_valid !== 1'b1 || int'(bus.out_data) != exp ||
                    bus.in_ready !== 1'b0 || bus.busy !== 1'b1) bad++;
            end
            check({name, " hold"}, bad, 0);
        end
        bus.out_ready = 1'b1;
        tick();
        check({name, " post-handshake v/r/b"},
              int'({bus.out_valid, bus.in_ready, bus.busy}), 3'b010);
    endtask

    // exp < 0 selects the reference model's median
    task automatic feed(input logic [7:0] d, input int stall, input int exp, input string name);
        bit full;
        full = model_push(d);
        push(d, name);
        if (!full) begin
            check({name, " no output"}, int'({bus.out_valid, bus.busy}), 0);
        end else begin
            expect_out((exp >= 0) ? exp : model_median(), stall, name);
        end
    endtask

    task automatic do_flush(input string name);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        model_flush();
        check({name, " flush v/r/b"}, int'({bus.out_valid, bus.in_ready, bus.busy}), 3'b010);
    endtask

    task automatic scenario_one(input string name);
        feed(8'd10, 0, -1, name);
        feed(8'd20, 0, -1, name);
        feed(8'd30, 0, -1, name);
        feed(8'd40, 0, -1, name);
        feed(8'd50, 0, 30, name);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        tbl[0].s = '{8'd7,   8'd7,   8'd7,   8'd3,   8'd9};   tbl[0].med = 7;   tbl[0].stall = 0;
        tbl[1].s = '{8'd200, 8'd1,   8'd200, 8'd1,   8'd128}; tbl[1].med = 128; tbl[1].stall = 1;
        tbl[2].s = '{8'd5,   8'd4,   8'd3,   8'd2,   8'd1};   tbl[2].med = 3;   tbl[2].stall = 0;
        tbl[3].s = '{8'd0,   8'd255, 8'd0,   8'd255, 8'd0};   tbl[3].med = 0;   tbl[3].stall = 3;
        tbl[4].s = '{8'd255, 8'd255, 8'd254, 8'd255, 8'd254}; tbl[4].med = 255; tbl[4].stall = 0;
        tbl[5].s = '{8'd9,   8'd9,   8'd1,   8'd1,   8'd5};   tbl[5].med = 5;   tbl[5].stall = 2;

        // Reset state
        #2;
        check("reset v/r/b", int'({bus.out_valid, bus.in_ready, bus.busy}), 0);
        check("reset out_data", int'(bus.out_data), 0);
        tick();
        tick();
        rst_n = 1'b1;
        check("idle in_ready", int'(bus.in_ready), 0);
        tick();
        check("accept in_ready", int'(bus.in_ready), 1);
        model_flush();

        // Fill, first median, sliding window
        scenario_one("s1");
        feed(8'd0,   0, 30, "s2a");
        feed(8'd255, 0, 40, "s2b");

        // Fixed windows from a fresh start
        for (int i = 0; i < 6; i++) begin
            do_flush("tbl");
            for (int j = 0; j < 5; j++) begin
                feed(tbl[i].s[j], tbl[i].stall, (j == 4) ? tbl[i].med : -1,
                     $sformatf("tbl%0d", i));
            end
        end

        // Long back-pressure in OUT
        do_flush("s4");
        for (int j = 0; j < 4; j++) feed(8'(j * 17 + 3), 0, -1, "s4");
        feed(8'd99, 20, -1, "s4");

        // Flush at sort step 4 discards the result and empties the window
        do_flush("s5");
        for (int j = 0; j < 4; j++) feed(8'(60 - j * 11), 0, -1, "s5");
        push(8'd77, "s5");
        repeat (4) tick();
        do_flush("s5 mid-sort");
        begin
            int seen = 0;
            for (int c = 0; c < 15; c++) begin
                tick();
                if (bus.out_valid === 1'b1) seen++;
            end
            check("s5 no out_valid after flush", seen, 0);
        end
        for (int j = 0; j < 5; j++) feed(8'(j * 40 + 5), 0, -1, "s5 refill");

        // Sample offered together with flush is dropped
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd250;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        model_flush();
        for (int j = 0; j < 5; j++) feed(8'(j + 1), 0, -1, "flush+sample");

        // Reset while holding a result in OUT
        do_flush("s6");
        for (int j = 0; j < 4; j++) feed(8'(j + 100), 0, -1, "s6");
        void'(model_push(8'd104));
        push(8'd104, "s6");
        bus.out_ready = 1'b0;
        begin
            int w = 0;
            while (bus.out_valid !== 1'b1 && w < 14) begin
                tick();
                w++;
            end
            check("s6 reached OUT", int'(bus.out_valid), 1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("s6 async reset v/r/b", int'({bus.out_valid, bus.in_ready, bus.busy}), 0);
        check("s6 async reset out_data", int'(bus.out_data), 0);
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        model_flush();
        scenario_one("s6 replay");

        // Randomized stream against the reference model
        for (int n = 0; n < 60; n++) begin
            logic [7:0] d;
            if ($urandom_range(0, 9) == 0) do_flush("rand");
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            feed(d, int'($urandom_range(0, 3)), -1, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
